// File: rtl/gray_sweep_ctrl.sv
// gray_sweep_ctrl: sweeps a binary index from first to last (up or down) and
// presents each index with its Gray code under a valid/ready handshake.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | waiting for start; b/g/cnt hold the result of the last sweep
// S_RUN  | valid word on b/g; steps on each accepted beat until last_l
// S_DONE | one-cycle done pulse after the final word was accepted
module gray_sweep_ctrl #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] first,
  input  logic [W-1:0] last,
  input  logic         abort,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] b,
  output logic [W-1:0] g,
  output logic         busy,
  output logic         done,
  output logic [W:0]   cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [W-1:0] ONE_B = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W:0]   ONE_C = {{W{1'b0}}, 1'b1};

  state_t       r_state;
  logic [W-1:0] r_last;
  logic         r_dir_dn;
  logic         r_valid;
  logic [W-1:0] r_b;
  logic [W-1:0] r_g;
  logic         r_busy;
  logic         r_done;
  logic [W:0]   r_cnt;

  logic         w_hs;
  logic [W-1:0] w_b_next;
  logic [W-1:0] w_g_next;
  logic [W-1:0] w_g_first;

  function automatic logic [W-1:0] gray(input logic [W-1:0] x);
    return x ^ (x >> 1);
  endfunction

  // Handshake and next-index datapath; gray of the stepped index is ready
  // in the same edge that b moves.
  always_comb begin
    w_hs      = r_valid & ready;
    w_b_next  = r_dir_dn ? (r_b - ONE_B) : (r_b + ONE_B);
    w_g_next  = gray(w_b_next);
    w_g_first = gray(first);
  end

  // Sweep sequencer with registered outputs; abort wins over completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_last   <= '0;
      r_dir_dn <= 1'b0;
      r_valid  <= 1'b0;
      r_b      <= '0;
      r_g      <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_last   <= last;
            r_dir_dn <= (last < first);
            r_b      <= first;
            r_g      <= w_g_first;
            r_cnt    <= '0;
            r_valid  <= 1'b1;
            r_busy   <= 1'b1;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          if (abort) begin
            if (w_hs) r_cnt <= r_cnt + ONE_C;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (w_hs) begin
            r_cnt <= r_cnt + ONE_C;
            if (r_b == r_last) begin
              r_valid <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_b <= w_b_next;
              r_g <= w_g_next;
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign valid = r_valid;
  assign b     = r_b;
  assign g     = r_g;
  assign busy  = r_busy;
  assign done  = r_done;
  assign cnt   = r_cnt;

endmodule

// File: doc/gray_sweep_ctrl.md
Name: gray_sweep_ctrl

Overview:
Sequencer that drives a binary-to-gray datapath through a programmed code range, one word per accepted beat. On start it sweeps a binary index from `first` to `last`, up or down, and emits each index with its Gray code under a valid/ready handshake. Used to generate Gray-code address/encoder test sequences and sweeps for downstream position and counter logic.

Parameters:
- W, 4, data width of the binary index and the Gray code.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a sweep; sampled only in IDLE.
- first  input  W  first binary index; latched on an accepted start.
- last  input  W  final binary index; latched on an accepted start.
- abort  input  1  terminate the sweep; sampled in RUN only.
- ready  input  1  downstream accepts the current word.
- valid  output  1  b/g hold a valid word.
- b  output  W  current binary index.
- g  output  W  Gray code of b, equal to b ^ (b >> 1), registered.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse after the final word is accepted.
- cnt  output  W+1  number of words accepted in the current or most recent sweep.

Behaviour:
- Reset (rst=1 at an edge, from any state, including mid-sweep):
  - state goes to IDLE.
  - valid, busy and done go to 0.
  - b, g and cnt go to 0.
  - Latched first/last are cleared to 0.
  - rst has priority over every other input.
- States:
  - IDLE: valid=0, busy=0. If start=1 at an edge: latch first/last, set dir=down when last<first, otherwise up. Load b=first, g=gray(first), cnt=0, go to RUN. In the next cycle valid=1 and busy=1, so latency from start to the first valid word is 1 cycle.
  - RUN: valid=1. A handshake is valid&ready at an edge.
    - On a handshake with b!=last_l: cnt+=1; b steps by +1 (up) or −1 (down); g is updated to gray of the new b in the same edge.
    - On a handshake with b==last_l: cnt+=1, valid goes to 0, go to DONE.
    - With ready=0: b, g, valid and cnt hold stable, for an unbounded number of cycles.
  - DONE: done=1 and busy=1 for exactly one cycle, valid=0. Then go to IDLE; b, g and cnt keep their final values.
- abort in RUN:
  - Go to IDLE at that edge; valid=0 and busy=0 in the next cycle; no done pulse.
  - If abort and a handshake occur at the same edge, the word counts as accepted (cnt increments) and abort still wins, so no DONE.
- start while busy (RUN or DONE) is ignored; first/last changes while busy are ignored.
- start in the same cycle DONE returns to IDLE is not accepted; start is accepted from the following cycle on.
- first==last: exactly one word, then DONE.
- Index arithmetic is W-bit. A sweep never wraps because it stops at last_l; a full range of 2^W words gives cnt=2^W, which is why cnt is W+1 bits.
- g is always gray(b), including while valid=0.

Test Plan:
1. Reset: assert rst for 2 cycles, including once mid-sweep → next cycle valid=0, busy=0, done=0, b=0, g=0, cnt=0.
2. Full up sweep, W=4, first=0, last=15, ready=1:
   - valid rises 1 cycle after start.
   - g sequence is 0,1,3,2,6,7,5,4,12,13,15,14,10,11,9,8 on 16 consecutive cycles.
   - done pulses once in the following cycle; cnt=16; busy falls one cycle after done.
3. Down sweep, first=9, last=5 → b sequence 9,8,7,6,5 and g sequence 13,12,4,5,7; cnt=5; single done pulse.
4. Backpressure, first=2, last=6: hold ready=0 for 3 cycles while b=4 → b=4 and g=6 stay stable and cnt stays at 2. After ready rises, the sweep completes with b=5 (g=7) then b=6 (g=5).
5. Single word, first=last=10 → one beat with b=10, g=15, then done; cnt=1.
6. Control edge cases, first=0, last=7:
   - start pulsed during RUN → no restart.
   - abort asserted with b=3 → valid=0 next cycle, busy=0, no done, cnt=3.
   - A new start afterwards runs normally from 0.
